// File: rtl/shared_counter_scheduler.sv
// Round-robin time-sharing of a single up-counter among NUM_REQ one-shot interval requesters.
// The owner's interval is latched at grant. Completion and abort are reported with the owner id.
module shared_counter_scheduler #(
  parameter  int NUM_REQ   = 4,
  parameter  int MAX_VALUE = 64,
  localparam int CNT_W     = $clog2(MAX_VALUE + 1),
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic [CNT_W-1:0]         count,
  output logic                     done,
  output logic                     abort,
  output logic [ID_W-1:0]          done_id
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  owner;
  logic [CNT_W-1:0] tgt;

  logic [ID_W-1:0]  winner;
  logic             found;
  int               idx;
  logic [CNT_W-1:0] req_len;
  logic [CNT_W-1:0] tgt_next;
  logic [ID_W-1:0]  ptr_after;

  // First requester at or above ptr, wrapping; lower ids lose ties after a wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign req_len   = len[winner*CNT_W +: CNT_W];
  assign tgt_next  = (req_len > CNT_W'(MAX_VALUE)) ? CNT_W'(MAX_VALUE) : req_len;
  assign ptr_after = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
  assign busy      = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      tgt     <= '0;
      grant   <= '0;
      count   <= '0;
      done    <= 1'b0;
      abort   <= 1'b0;
      done_id <= '0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= RUN;
            grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
            owner <= winner;
            tgt   <= tgt_next;
            count <= '0;
          end
        end
        RUN: begin
          // A dropped request wins over a simultaneous terminal count.
          if (!req[owner]) begin
            state   <= IDLE;
            grant   <= '0;
            count   <= '0;
            abort   <= 1'b1;
            done_id <= owner;
            ptr     <= ptr_after;
          end else if (count == tgt) begin
            state   <= DONE;
            grant   <= '0;
            count   <= '0;
            done    <= 1'b1;
            done_id <= owner;
            ptr     <= ptr_after;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_counter_scheduler.sv
// Directed bench for shared_counter_scheduler: reset, single run, round-robin, clamp,
// zero length, abort, input stability and async reset mid-run.
module tb_shared_counter_scheduler;

  localparam int NUM_REQ   = 4;
  localparam int MAX_VALUE = 64;
  localparam int CNT_W     = 7;
  localparam int ID_W      = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [CNT_W-1:0]         count;
  logic                     done;
  logic                     abort;
  logic [ID_W-1:0]          done_id;

  int vectors     = 0;
  int miscompares = 0;

  shared_counter_scheduler #(.NUM_REQ(NUM_REQ), .MAX_VALUE(MAX_VALUE)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len     (len),
    .grant   (grant),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .abort   (abort),
    .done_id (done_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input logic [CNT_W-1:0] v);
    len[i*CNT_W +: CNT_W] = v;
  endtask

  initial begin
    int order [5];
    logic [3:0] exp_g;
    order = '{0, 1, 2, 3, 0};

    reset = 1'b1;
    req   = '0;
    len   = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_abort", 32'(abort), 32'h0);
    check("rst_done_id", 32'(done_id), 32'h0);

    // Round-robin with all lengths zero: grant, done one edge later, then an idle cycle.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << order[k];
      tick();
      check("rr_grant", 32'(grant), 32'(exp_g));
      check("rr_count0", 32'(count), 32'h0);
      tick();
      check("rr_done", 32'(done), 32'h1);
      check("rr_done_id", 32'(done_id), 32'(order[k]));
      check("rr_grant_off", 32'(grant), 32'h0);
      tick();
      check("rr_done_clear", 32'(done), 32'h0);
    end
    req = 4'b0000;
    tick();
    check("rr_idle", 32'(busy), 32'h0);

    // Single request, length 3.
    set_len(1, 7'd3);
    req = 4'b0010;
    tick();
    check("single_grant", 32'(grant), 32'h2);
    check("single_busy", 32'(busy), 32'h1);
    check("single_c0", 32'(count), 32'h0);
    tick();
    check("single_c1", 32'(count), 32'h1);
    tick();
    check("single_c2", 32'(count), 32'h2);
    tick();
    check("single_c3", 32'(count), 32'h3);
    check("single_busy3", 32'(busy), 32'h1);
    tick();
    check("single_done", 32'(done), 32'h1);
    check("single_done_id", 32'(done_id), 32'h1);
    check("single_busy_low", 32'(busy), 32'h0);
    check("single_count_zero", 32'(count), 32'h0);
    req = 4'b0000;
    tick();
    check("single_done_pulse", 32'(done), 32'h0);

    // Clamp: 127 runs to 64.
    set_len(2, 7'd127);
    req = 4'b0100;
    tick();
    check("clamp_grant", 32'(grant), 32'h4);
    for (int k = 0; k < 64; k++) tick();
    check("clamp_count64", 32'(count), 32'd64);
    check("clamp_busy", 32'(busy), 32'h1);
    tick();
    check("clamp_done", 32'(done), 32'h1);
    check("clamp_done_id", 32'(done_id), 32'h2);
    check("clamp_count_zero", 32'(count), 32'h0);

    // Zero length: exactly one RUN cycle. ptr is 3 here, so the winner wraps back to 2.
    set_len(2, 7'd0);
    tick();
    check("zero_idle", 32'(done), 32'h0);
    tick();
    check("zero_grant", 32'(grant), 32'h4);
    check("zero_count", 32'(count), 32'h0);
    tick();
    check("zero_done", 32'(done), 32'h1);
    check("zero_busy", 32'(busy), 32'h0);
    req = 4'b0000;
    tick();

    // Abort at count 4.
    set_len(3, 7'd10);
    req = 4'b1000;
    tick();
    check("abort_grant", 32'(grant), 32'h8);
    for (int k = 0; k < 4; k++) tick();
    check("abort_count4", 32'(count), 32'h4);
    req = 4'b0000;
    tick();
    check("abort_pulse", 32'(abort), 32'h1);
    check("abort_no_done", 32'(done), 32'h0);
    check("abort_done_id", 32'(done_id), 32'h3);
    check("abort_grant_off", 32'(grant), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    tick();
    check("abort_pulse_end", 32'(abort), 32'h0);
    check("abort_still_no_done", 32'(done), 32'h0);

    // Drop exactly at terminal count: abort wins.
    req = 4'b1000;
    tick();
    check("abort_tc_grant", 32'(grant), 32'h8);
    for (int k = 0; k < 10; k++) tick();
    check("abort_tc_count", 32'(count), 32'd10);
    req = 4'b0000;
    tick();
    check("abort_tc_abort", 32'(abort), 32'h1);
    check("abort_tc_no_done", 32'(done), 32'h0);
    check("abort_tc_id", 32'(done_id), 32'h3);
    tick();
    check("abort_tc_after", 32'(done), 32'h0);

    // Stability: len and other reqs change mid-run.
    set_len(0, 7'd20);
    req = 4'b0001;
    tick();
    check("stab_grant", 32'(grant), 32'h1);
    tick();
    set_len(0, 7'd2);
    req = 4'b1111;
    for (int k = 0; k < 19; k++) tick();
    check("stab_count20", 32'(count), 32'd20);
    check("stab_grant_held", 32'(grant), 32'h1);
    tick();
    check("stab_done", 32'(done), 32'h1);
    check("stab_done_id", 32'(done_id), 32'h0);
    req = 4'b0000;
    tick();

    // Asynchronous reset mid-run with count 5; ptr is 1 beforehand.
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 7'd10);
    req = 4'b1111;
    tick();
    check("rst2_grant_pre", 32'(grant), 32'h2);
    for (int k = 0; k < 5; k++) tick();
    check("rst2_count5", 32'(count), 32'h5);
    #2;
    reset = 1'b1;
    #1;
    check("rst2_grant", 32'(grant), 32'h0);
    check("rst2_busy", 32'(busy), 32'h0);
    check("rst2_count", 32'(count), 32'h0);
    check("rst2_done", 32'(done), 32'h0);
    check("rst2_abort", 32'(abort), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("rst2_first_grant", 32'(grant), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
